uart_rx_byte: RTL and testbench
===============================

// Module: uart_rx_byte
// PURPOSE
//  8N1 UART receiver feeding the LED panel core's byte input; sits between the board RX pin and led_panel_single.
//  Synchronises the async line, frames bytes with mid-bit sampling and presents them on a valid/ready port.
//  Flags framing errors and overruns; the last accepted byte stays on data_out for the panel to read.
// PARAMETERS
//  CLKS_PER_BIT  8  clk cycles per UART bit; legal range 4..65535
//  PARITY_ODD    0  parity sense: 0 = even, 1 = odd; used only when UART_RX_PARITY_EN is defined
// PORTS
//  clk            in   1  single clock; all logic on its rising edge
//  reset_n        in   1  asynchronous, active-low reset
//  rx_in          in   1  raw UART line; idles high; asynchronous to clk
//  data_out       out  8  received byte, LSB = first data bit
//  valid_out      out  1  data_out holds an unconsumed byte
//  ready_in       in   1  consumer accepts data_out when valid_out && ready_in
//  frame_err_out  out  1  one-cycle pulse: stop bit (or parity) was bad; byte dropped
//  overrun_out    out  1  one-cycle pulse: byte completed while the previous byte was still pending; new byte dropped
// BEHAVIOUR
//  Reset: data_out=0, valid_out=0, frame_err_out=0, overrun_out=0, FSM=IDLE, synchroniser flops=1.
//  rx_in passes through a 2-flop synchroniser to give rx_s. All sampling below uses rx_s.
//  Bit counter is log2(CLKS_PER_BIT) wide. It reloads on every state entry.
//  IDLE : rx_s==0 -> START with counter cleared.
//  START: at count CLKS_PER_BIT/2-1, if rx_s==0 -> DATA, else -> IDLE (glitch rejected, no flags).
//  DATA : sample every CLKS_PER_BIT cycles at mid-bit; shift right so bit 0 arrives first. After 8 samples -> STOP (or PARITY).
//  STOP : sample at mid-bit. If rx_s==1 the byte is good -> IDLE. If rx_s==0, pulse frame_err -> BREAK.
//  BREAK: wait for rx_s==1, then -> IDLE. No start bit is detected while the line is held low.
//  Latency: valid_out rises on the cycle after the stop-bit mid-sample, about 9.5 bit times after the start edge plus 2 synchroniser cycles.
//  Handshake: a transfer happens when valid_out && ready_in.
//   - valid_out clears on the cycle after the transfer.
//   - data_out is never cleared and holds its value until the next good byte.
//  Good byte with valid_out==0 -> load data_out, set valid_out.
//  Good byte with a pending byte:
//   - If ready_in==1 in the same cycle, load the new byte and keep valid_out=1. No overrun.
//   - Otherwise pulse overrun_out, keep the old byte, drop the new one.
//  frame_err_out and overrun_out are never asserted together. Each is high for exactly one cycle.
//  reset_n falling in any state forces the reset values immediately. The partial frame is discarded.
//  After reset is released, a line already low is treated as a start edge.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//   - A PARITY state is inserted between DATA and STOP and samples a 9th bit.
//   - Check: (^data ^ parity_bit) must equal PARITY_ODD.
//   - On mismatch, pulse frame_err_out at the stop-bit sample. The byte is dropped, and the FSM goes to BREAK only if the stop bit is also 0.
//  UART_RX_PARITY_EN undefined: pure 8N1. No PARITY state exists, and PARITY_ODD is unused.
// STRUCTURE
//  Package uart_rx_pkg:
//   - FSM state enum: IDLE, START, DATA, PARITY, STOP, BREAK.
//   - Constants UART_DATA_BITS=8 and UART_IDLE_LEVEL=1'b1.
//  Sub-module uart_rx_bit_timer:
//   - A counter with a restart input.
//   - Outputs mid_tick, a pulse at CLKS_PER_BIT/2-1, and bit_tick, a pulse every CLKS_PER_BIT cycles after mid.
//  The top level holds the synchroniser, FSM, shift register, parity and output register.
// TESTING
//  1 Reset: hold reset_n=0 with rx_in toggling -> all outputs 0. Release -> no valid_out for 20 bit times with rx_in=1.
//  2 Send 0xA5 with ready_in=1 -> valid_out high for exactly 1 cycle, data_out=0xA5 and held afterwards. No flags.
//  3 Glitch: rx_in low for CLKS_PER_BIT/4 cycles -> FSM returns to IDLE. No valid_out, no flags.
//  4 Send 0x3C with stop bit 0 -> one frame_err_out pulse and no valid_out. Hold the line low 3 bytes, release, send 0x11 -> data_out=0x11.
//  5 ready_in=0: send 0x01 then 0x02 -> valid_out=1, data_out=0x01, one overrun_out pulse.
//    Repeat with ready_in=1 in the completion cycle of 0x02 -> data_out=0x02, no overrun.
//  6 Assert reset_n mid-DATA of 0xFF, release, send 0x5A -> only 0x5A delivered.
//    With UART_RX_PARITY_EN and PARITY_ODD=0: send 0x07 with parity 0 -> frame_err_out pulse, no valid.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the uart_rx_byte receiver.
//   uart_rx_state_e  : receiver FSM states
//   UART_DATA_BITS   : data bits per frame
//   UART_IDLE_LEVEL  : line level when idle / stop bit level
package uart_rx_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam logic        UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit-period timer for the UART receiver.
// The counter runs 0..CLKS_PER_BIT-1 and wraps; restart forces it to 0 on
// the next edge so every FSM state starts with a fresh count.
// Ports:
//   clk       in  clock
//   reset_n   in  asynchronous active-low reset
//   restart   in  reload counter to 0
//   mid_tick  out high while count == CLKS_PER_BIT/2-1 (start-bit centre)
//   bit_tick  out high while count == CLKS_PER_BIT-1 (one bit after a mid point)
module uart_rx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic mid_tick,
  output logic bit_tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (restart || cnt == LAST_CNT) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // A state entered with restart at edge T sees mid_tick at T+CLKS_PER_BIT/2
  // and bit_tick at T+CLKS_PER_BIT, i.e. one full bit after the previous sample.
  assign mid_tick = (cnt == MID_CNT);
  assign bit_tick = (cnt == LAST_CNT);

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with a valid/ready byte output.
// Optional feature: define UART_RX_PARITY_EN to receive 8 data bits plus a
// parity bit (sense set by PARITY_ODD: 0 = even, 1 = odd).
// Ports:
//   clk            in   clock
//   reset_n        in   asynchronous active-low reset
//   rx_in          in   raw UART line, idles high, asynchronous to clk
//   data_out       out  last accepted byte, LSB = first data bit
//   valid_out      out  data_out holds an unconsumed byte
//   ready_in       in   consumer takes data_out when valid_out && ready_in
//   frame_err_out  out  one-cycle pulse: bad stop (or parity) bit, byte dropped
//   overrun_out    out  one-cycle pulse: new byte dropped, previous still pending
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  input  logic       ready_in,
  output logic       frame_err_out,
  output logic       overrun_out
);

  import uart_rx_pkg::*;

  localparam int unsigned BIT_IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(UART_DATA_BITS - 1);

  uart_rx_state_e state, state_next;

  logic [1:0]                sync;
  logic                      rx_s;
  logic                      restart;
  logic                      mid_tick;
  logic                      bit_tick;
  logic                      sample_data;
  logic                      stop_sample;
  logic [BIT_IDX_W-1:0]      bit_idx;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic                      parity_ok;
  logic                      byte_good;
  logic                      frame_bad;

  // Two-flop synchroniser, reset to the idle level so reset release is quiet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= {2{UART_IDLE_LEVEL}};
    end else begin
      sync <= {sync[0], rx_in};
    end
  end

  assign rx_s = sync[1];

  uart_rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (restart),
    .mid_tick(mid_tick),
    .bit_tick(bit_tick)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (rx_s != UART_IDLE_LEVEL) state_next = START;
      end
      START: begin
        if (mid_tick) state_next = (rx_s == UART_IDLE_LEVEL) ? IDLE : DATA;
      end
      DATA: begin
        if (bit_tick && bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
      PARITY: begin
        if (bit_tick) state_next = STOP;
      end
      STOP: begin
        if (bit_tick) state_next = (rx_s == UART_IDLE_LEVEL) ? IDLE : BREAK;
      end
      BREAK: begin
        if (rx_s == UART_IDLE_LEVEL) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic sample_parity;
  logic parity_bit;
`endif

  // Output / strobe logic
  always_comb begin
    restart     = (state_next != state);
    sample_data = (state == DATA) && bit_tick;
    stop_sample = (state == STOP) && bit_tick;
`ifdef UART_RX_PARITY_EN
    sample_parity = (state == PARITY) && bit_tick;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_idx <= '0;
    end else if (state != DATA) begin
      bit_idx <= '0;
    end else if (sample_data) begin
      bit_idx <= bit_idx + BIT_IDX_W'(1);
    end
  end

  // Shift right so the first data bit ends up in bit 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= '0;
    end else if (sample_data) begin
      shift_reg <= {rx_s, shift_reg[UART_DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_bit <= 1'b0;
    end else if (sample_parity) begin
      parity_bit <= rx_s;
    end
  end

  assign parity_ok = (((^shift_reg) ^ parity_bit) == 1'(PARITY_ODD));
`else
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
  assign parity_ok         = 1'b1;
`endif

  // A parity error with a good stop bit still returns to IDLE; only a low
  // stop bit sends the FSM to BREAK. Either way a single frame_err pulse.
  assign byte_good = stop_sample && (rx_s == UART_IDLE_LEVEL) && parity_ok;
  assign frame_bad = stop_sample && !((rx_s == UART_IDLE_LEVEL) && parity_ok);

  // Output register and valid/ready handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out      <= '0;
      valid_out     <= 1'b0;
      frame_err_out <= 1'b0;
      overrun_out   <= 1'b0;
    end else begin
      frame_err_out <= frame_bad;
      overrun_out   <= byte_good && valid_out && !ready_in;
      if (byte_good && (!valid_out || ready_in)) begin
        data_out  <= shift_reg;
        valid_out <= 1'b1;
      end else if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: directed scenarios plus randomized
// frames, checked against a frame-level model of the receiver's output port.
// Build with UART_RX_PARITY_EN defined to exercise the parity frame format.
module tb_uart_rx_byte;

  localparam int unsigned CPB   = 8;
  localparam int unsigned HALF  = CPB / 2;
  localparam int unsigned P_ODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       ready_in;
  logic       frame_err_out;
  logic       overrun_out;

  uart_rx_byte #(
    .CLKS_PER_BIT(CPB),
    .PARITY_ODD  (P_ODD)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_in        (rx_in),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .frame_err_out(frame_err_out),
    .overrun_out  (overrun_out)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Observed behaviour, collected on the falling edge.
  logic [7:0]  got_q[$];
  int unsigned ferr_cnt = 0;
  int unsigned ovr_cnt = 0;
  int unsigned valid_cycles = 0;
  int unsigned viol = 0;
  logic        prev_ferr = 1'b0;
  logic        prev_ovr = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_ferr = 1'b0;
      prev_ovr  = 1'b0;
    end else begin
      if (valid_out && ready_in) got_q.push_back(data_out);
      if (frame_err_out) ferr_cnt++;
      if (overrun_out) ovr_cnt++;
      if (valid_out) valid_cycles++;
      if (frame_err_out && overrun_out) viol++;
      if (frame_err_out && prev_ferr) viol++;
      if (overrun_out && prev_ovr) viol++;
      prev_ferr = frame_err_out;
      prev_ovr  = overrun_out;
    end
  end

  // Frame-level reference model.
  logic [7:0]  exp_data = 8'h00;
  bit          exp_pending = 1'b0;
  logic [7:0]  exp_q[$];
  int unsigned exp_ferr = 0;
  int unsigned exp_ovr = 0;

  task automatic idle_cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame. With ready_pulse, ready_in is high only for the cycle
  // whose closing edge is the stop-bit centre sample (9.5 bits + sync delay).
  task automatic send_line(input logic [7:0] b, input logic stop, input bit par_bad,
                           input bit ready_pulse);
    logic line[$];
    line.push_back(1'b0);
    for (int i = 0; i < 8; i++) line.push_back(b[i]);
`ifdef UART_RX_PARITY_EN
    line.push_back((^b) ^ 1'(P_ODD) ^ par_bad);
`endif
    line.push_back(stop);
    for (int k = 0; k < line.size(); k++) begin
      rx_in = line[k];
      for (int c = 1; c <= CPB; c++) begin
        @(posedge clk);
        #1;
        if (ready_pulse && k == line.size() - 1) begin
          if (c == HALF + 2) ready_in = 1'b1;
          else if (c == HALF + 3) ready_in = 1'b0;
        end
      end
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, " data_out"}, data_out, exp_data);
    check({tag, " valid_out"}, valid_out, exp_pending);
    check({tag, " frame_errs"}, ferr_cnt, exp_ferr);
    check({tag, " overruns"}, ovr_cnt, exp_ovr);
    check({tag, " xfer_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, " xfer_byte"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  // mode 0: ready_in low; mode 1: ready_in held high; mode 2: ready_in high
  // only in the completion cycle.
  task automatic do_frame(input logic [7:0] b, input logic stop, input bit par_bad,
                          input int unsigned mode, input int unsigned hold_bits);
    bit good;
    bit ready_c;
    bit pend0;
    if (mode == 1) begin
      ready_in = 1'b1;
      if (exp_pending) begin
        exp_q.push_back(exp_data);
        exp_pending = 1'b0;
      end
    end else begin
      ready_in = 1'b0;
    end
    idle_cycles(2);
    send_line(b, stop, par_bad, mode == 2);
    if (hold_bits != 0) begin
      rx_in = 1'b0;
      idle_cycles(hold_bits * CPB);
    end
    rx_in = 1'b1;
    idle_cycles(2 * CPB);

    good    = stop && !(PAR_EN && par_bad);
    ready_c = (mode != 0);
    pend0   = exp_pending;
    if (ready_c && pend0) begin
      exp_q.push_back(exp_data);
      exp_pending = 1'b0;
    end
    if (!good) begin
      exp_ferr++;
    end else if (pend0 && !ready_c) begin
      exp_ovr++;
    end else begin
      exp_data    = b;
      exp_pending = 1'b1;
      if (mode == 1) begin
        exp_q.push_back(b);
        exp_pending = 1'b0;
      end
    end
  endtask

  initial begin
    int unsigned vc0;
    reset_n  = 1'b0;
    rx_in    = 1'b1;
    ready_in = 1'b0;

    // Reset held while the line toggles
    for (int i = 0; i < 12; i++) begin
      rx_in = $urandom_range(0, 1);
      idle_cycles(1);
    end
    check("rst data_out", data_out, 8'h00);
    check("rst valid_out", valid_out, 1'b0);
    check("rst frame_err", frame_err_out, 1'b0);
    check("rst overrun", overrun_out, 1'b0);
    rx_in   = 1'b1;
    idle_cycles(2);
    reset_n = 1'b1;
    idle_cycles(20 * CPB);
    check("post_rst valid_cycles", valid_cycles, 0);
    check_state("post_rst");

    // 0xA5 with consumer ready
    vc0 = valid_cycles;
    do_frame(8'hA5, 1'b1, 1'b0, 1, 0);
    check("a5 valid_cycles", valid_cycles - vc0, 1);
    idle_cycles(4 * CPB);
    check_state("a5");

    // Short glitch must be rejected
    vc0 = valid_cycles;
    rx_in = 1'b0;
    idle_cycles(CPB / 4);
    rx_in = 1'b1;
    idle_cycles(3 * CPB);
    check("glitch valid_cycles", valid_cycles - vc0, 0);
    check_state("glitch");

    // Bad stop bit, line held low, then a good byte
    do_frame(8'h3C, 1'b0, 1'b0, 1, 30);
    check_state("stop_err");
    do_frame(8'h11, 1'b1, 1'b0, 1, 0);
    check_state("after_break");

    // Overrun, then a same-cycle accept
    do_frame(8'h01, 1'b1, 1'b0, 0, 0);
    do_frame(8'h02, 1'b1, 1'b0, 0, 0);
    check_state("overrun");
    do_frame(8'h02, 1'b1, 1'b0, 2, 0);
    check_state("same_cycle_accept");

    // Reset in the middle of a frame
    ready_in = 1'b1;
    exp_q.push_back(exp_data);
    exp_pending = 1'b0;
    idle_cycles(4);
    check_state("drain");
    fork
      send_line(8'hFF, 1'b1, 1'b0, 1'b0);
      begin
        idle_cycles(4 * CPB);
        reset_n = 1'b0;
        #2;
        check("async_rst data_out", data_out, 8'h00);
        check("async_rst valid_out", valid_out, 1'b0);
        idle_cycles(3);
        reset_n = 1'b1;
      end
    join
    exp_data = 8'h00;
    exp_pending = 1'b0;
    rx_in = 1'b1;
    idle_cycles(2 * CPB);
    check_state("mid_frame_rst");
    do_frame(8'h5A, 1'b1, 1'b0, 1, 0);
    check_state("after_rst_5a");

`ifdef UART_RX_PARITY_EN
    do_frame(8'h07, 1'b1, 1'b1, 1, 0);
    check_state("parity_err");
`endif

    // Randomized frames
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      logic       stop;
      bit         pb;
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      pb   = PAR_EN && ($urandom_range(0, 4) == 0);
      do_frame(b, stop, pb, $urandom_range(0, 2), 0);
      check_state("rand");
    end

    ready_in = 1'b1;
    if (exp_pending) begin
      exp_q.push_back(exp_data);
      exp_pending = 1'b0;
    end
    idle_cycles(4);
    check_state("final");
    check("pulse_rules", viol, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
